// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of a 2-bit ALU.
//   Commands {op,b,a} are queued in a DEPTH-entry FIFO. One command at a time
//   is held on the ALU inputs for ALU_LAT cycles of WAIT. The ALU outputs are
//   then captured and offered downstream until the consumer accepts them.
// Optional feature: define ALU_ISSUE_CHECK_EN to add the res_err output. It
//   flags a captured op-0 (add) result that disagrees with a+b.
module alu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_a,
  input  logic [1:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [1:0] alu_s,
  output logic       alu_en,
  input  logic [3:0] alu_y,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_y,
  output logic       res_carry,
  output logic       res_zero,
  output logic [1:0] res_op,
  output logic       busy,
  output logic [7:0] done_cnt
`ifdef ALU_ISSUE_CHECK_EN
  ,
  output logic       res_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] b;
    logic [1:0] a;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  state_t        state, state_nx;
  cmd_t          cur;
  logic [2:0]    lat_cnt;
  logic          capture, handshake;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full && !en;
  assign push      = cmd_valid && cmd_ready;

  assign alu_a  = cur.a;
  assign alu_b  = cur.b;
  assign alu_s  = cur.op;
  assign alu_en = (state == IDLE);
  assign busy   = (state != IDLE) || !empty;

  // FIFO storage write; only pushed slots are ever read back.
  // NOTE: the storage array has no reset. Occupancy is tracked by count, so a stale entry is never popped.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of 2.
  // NOTE: all sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk or posedge en) begin
    if (en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge en) begin
    if (en) state <= IDLE;
    else    state <= state_nx;
  end

  // Next-state decode, including pop, capture and result-handshake strobes.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (lat_cnt == 3'd0) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          handshake = 1'b1;
          if (!empty) begin
            pop      = 1'b1;
            state_nx = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand registers on the ALU inputs, and the latency counter that paces WAIT.
  always_ff @(posedge clk or posedge en) begin
    if (en) begin
      cur     <= '0;
      lat_cnt <= '0;
    end else begin
      if (pop) cur <= mem[rd_ptr];
      if (state == ISSUE)
        lat_cnt <= 3'(ALU_LAT - 1);
      else if (state == WAIT && lat_cnt != 3'd0)
        lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Result capture, downstream valid, and the count of completed handshakes.
  always_ff @(posedge clk or posedge en) begin
    if (en) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_op    <= '0;
      done_cnt  <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_y     <= alu_y;
        res_carry <= alu_carry;
        res_zero  <= alu_zero;
        res_op    <= cur.op;
      end else if (handshake) begin
        res_valid <= 1'b0;
      end
      if (handshake) done_cnt <= done_cnt + 8'd1;
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  logic [2:0] exp_sum;
  logic       chk_mismatch;

  assign exp_sum      = 3'(cur.a) + 3'(cur.b);
  assign chk_mismatch = (cur.op == 2'd0) &&
                        ((alu_y != {1'b0, exp_sum}) ||
                         (alu_carry != exp_sum[2]) ||
                         (alu_zero != (exp_sum == 3'd0)));

  // Add-result self check. It is sampled with the result and cleared once the result is taken.
  always_ff @(posedge clk or posedge en) begin
    if (en)             res_err <= 1'b0;
    else if (capture)   res_err <= chk_mismatch;
    else if (handshake) res_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random test of alu_issue_ctrl. The bench
// contains an ALU model that reports correct outputs only once its operands
// have been stable for long enough. A queue-based model of the expected results
// is checked at every result handshake.
module tb_alu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  logic       clk, en;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_a, cmd_b, cmd_op;
  logic [1:0] alu_a, alu_b, alu_s;
  logic       alu_en;
  logic [3:0] alu_y;
  logic       alu_carry, alu_zero;
  logic       res_valid, res_ready;
  logic [3:0] res_y;
  logic       res_carry, res_zero;
  logic [1:0] res_op;
  logic       busy;
  logic [7:0] done_cnt;
`ifdef ALU_ISSUE_CHECK_EN
  logic       res_err;
`endif

  alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_en(alu_en),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_carry(res_carry), .res_zero(res_zero), .res_op(res_op),
    .busy(busy), .done_cnt(done_cnt)
`ifdef ALU_ISSUE_CHECK_EN
    , .res_err(res_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour, returned as {zero, carry, y}.
  function automatic logic [5:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
    logic [3:0] y;
    logic       c;
    logic [2:0] sum;
    sum = 3'(a) + 3'(b);
    c   = 1'b0;
    case (s)
      2'd0:    begin y = {1'b0, sum}; c = sum[2]; end
      2'd1:    y = 4'(a) * 4'(b);
      2'd2:    y = {a, b};
      default: y = {2'b00, a ^ b};
    endcase
    return {(y == 4'd0), c, y};
  endfunction

  // ALU model: the outputs are wrong until the operands have been stable for enough edges.
  logic       alu_force, force_c, force_z;
  logic [3:0] force_y;
  logic [5:0] alu_prev;
  int         alu_age;
  logic [5:0] alu_good;
  logic       alu_ok;

  always @(posedge clk) begin
    if (alu_en || ({alu_s, alu_b, alu_a} != alu_prev)) alu_age <= 0;
    else if (alu_age < 15)                              alu_age <= alu_age + 1;
    alu_prev <= {alu_s, alu_b, alu_a};
  end

  always_comb begin
    alu_good = alu_force ? {force_z, force_c, force_y} : alu_fn(alu_a, alu_b, alu_s);
    alu_ok   = !alu_en && ({alu_s, alu_b, alu_a} == alu_prev) && (alu_age >= ALU_LAT - 1);
    {alu_zero, alu_carry, alu_y} = alu_ok ? alu_good : ~alu_good;
  end

  typedef struct {
    logic [7:0] res;   // {op, zero, carry, y}
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   hs_times[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, hs_cnt = 0;
  int   n, acc, seen, base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    exp_t       e;
    logic [5:0] good;
    logic [2:0] sum;
    good  = alu_force ? {force_z, force_c, force_y} : alu_fn(a, b, op);
    sum   = 3'(a) + 3'(b);
    e.res = {op, good};
    e.err = (op == 2'd0) && (good != {(sum == 3'd0), sum[2], 1'b0, sum});
    return e;
  endfunction

  // One clock. The model sees accepted commands and completed results before the edge.
  task automatic tick();
    exp_t e;
    if (!en && cmd_valid && cmd_ready) exp_q.push_back(make_exp(cmd_a, cmd_b, cmd_op));
    if (!en && res_valid && res_ready) begin
      check("exp_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 32'({res_op, res_zero, res_carry, res_y}), 32'(e.res));
`ifdef ALU_ISSUE_CHECK_EN
        check("res_err", 32'(res_err), 32'(e.err));
`endif
      end
      hs_cnt++;
      hs_times.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!en) check("done_cnt", 32'(done_cnt), 32'(hs_cnt[7:0]));
  endtask

  task automatic push_one(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    res_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    res_ready = 1'b0;
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    alu_force = 1'b0; force_y = '0; force_c = 1'b0; force_z = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          32'({cmd_ready, alu_a, alu_b, alu_s, alu_en, res_valid, res_y, res_carry, res_zero, res_op, busy, done_cnt}),
          32'({1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0}));
    en = 1'b0;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'(1));

    // A single command from idle: check its latency, ALU drive, captured fields and stall behaviour.
    push_one(2'd3, 2'd2, 2'd0);
    wait_res(n);
    check("latency", 32'(n), 32'(ALU_LAT + 2));
    check("alu_drive", 32'({alu_en, alu_s, alu_b, alu_a}), 32'({1'b0, 2'd0, 2'd2, 2'd3}));
    check("single_result", 32'({res_op, res_zero, res_carry, res_y}), 32'({2'd0, 1'b0, 1'b1, 4'd5}));
    repeat (3) tick();
    check("hold_stall", 32'({res_valid, res_y}), 32'({1'b1, 4'd5}));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("after_handshake", 32'({res_valid, busy, alu_en}), 32'(3'b001));

    // Reset while in WAIT: the command in flight is discarded.
    push_one(2'd3, 2'd2, 2'd0);
    tick();
    tick();
    check("in_wait", 32'({alu_en, busy}), 32'(2'b01));
    #2;
    en = 1'b1;
    exp_q.delete();
    hs_cnt = 0;
    #1;
    check("reset_mid_wait", 32'({res_valid, alu_en, busy, cmd_ready}), 32'(4'b0100));
    tick();
    tick();
    en = 1'b0;
    res_ready = 1'b1;
    seen = 0;
    repeat (15) begin
      tick();
      if (res_valid) seen++;
    end
    res_ready = 1'b0;
    check("no_result_after_reset", 32'(seen), 32'(0));
    check("idle_after_reset", 32'(busy), 32'(0));

    // Fill: with results blocked, 5 of 6 commands are accepted (1 in the ALU, DEPTH in the FIFO).
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 2'($urandom); cmd_b = 2'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_accepted", 32'(acc), 32'(DEPTH + 1));
    check("full_state", 32'({cmd_ready, res_valid, busy}), 32'(3'b011));
    drain("fill_drained");

    // Push and pop in the same cycle at count 2: occupancy stays 2, so only 2 more commands fit.
    for (int i = 0; i < 3; i++) push_one(2'($urandom), 2'($urandom), 2'($urandom));
    wait_res(n);
    check("pushpop_hold", 32'(res_valid), 32'(1));
    cmd_a = 2'($urandom); cmd_b = 2'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
    res_ready = 1'b1;
    check("pushpop_ready", 32'(cmd_ready), 32'(1));
    tick();
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_a = 2'($urandom); cmd_b = 2'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("count_after_pushpop", 32'(acc), 32'(2));
    drain("pushpop_drained");

    // Streaming 8 commands with res_ready held high: results arrive back-to-back.
    hs_times.delete();
    base = hs_cnt;
    res_ready = 1'b1;
    acc = 0;
    n = 0;
    while (acc < 8 && n < 200) begin
      cmd_a = 2'($urandom); cmd_b = 2'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (hs_times.size() < 8 && n < 200) begin
      tick();
      n++;
    end
    res_ready = 1'b0;
    check("stream_results", 32'(hs_times.size()), 32'(8));
    for (int i = 1; i < hs_times.size(); i++)
      check("stream_period", 32'(hs_times[i] - hs_times[i-1]), 32'(ALU_LAT + 2));
    check("stream_done_cnt", 32'(done_cnt), 32'(8'(base + 8)));

    // Random traffic on both sides, long enough for done_cnt to wrap.
    for (int i = 0; i < 2000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a = 2'($urandom); cmd_b = 2'($urandom); cmd_op = 2'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    drain("random_drained");
    check("random_wrapped", 32'(hs_cnt > 256), 32'(1));
    check("final_idle", 32'({busy, res_valid, alu_en}), 32'(3'b001));

`ifdef ALU_ISSUE_CHECK_EN
    // Add self-check: a wrong sum raises res_err, a right one does not.
    alu_force = 1'b1; force_y = 4'd1; force_c = 1'b0; force_z = 1'b0;
    push_one(2'd2, 2'd3, 2'd0);
    wait_res(n);
    check("res_err_bad", 32'({res_valid, res_err}), 32'(2'b11));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_err_cleared", 32'(res_err), 32'(0));
    force_y = 4'd5; force_c = 1'b1; force_z = 1'b0;
    push_one(2'd2, 2'd3, 2'd0);
    wait_res(n);
    check("res_err_good", 32'({res_valid, res_err}), 32'(2'b10));
    force_y = 4'd0;
    drain("check_drained");
    push_one(2'd2, 2'd3, 2'd1);
    wait_res(n);
    check("res_err_other_op", 32'({res_valid, res_err}), 32'(2'b10));
    drain("check_other_drained");
    alu_force = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
